printer_rx: RTL



---
 rtl/printer_pkg.sv | 14 +
 rtl/printer_rx_if.sv | 26 ++
 rtl/printer_rx_byte_fifo.sv | 57 +++++
 rtl/printer_rx.sv | 91 +++++++++
 4 files changed

// File: rtl/printer_pkg.sv
// Shared definitions for the printer-side receiver: state encoding, defaults, data width.
package printer_pkg;

  typedef enum logic [1:0] {
    ST_READY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_STALL = 2'd2
  } printer_state_t;

  localparam int PRINT_CYCLES_DEF = 8;
  localparam int FIFO_DEPTH_DEF   = 4;
  localparam int PD_W             = 8;

endpackage

// File: rtl/printer_rx_if.sv
// POC-facing strobe/ready handshake plus consumer valid/ready port and status of printer_rx.
interface printer_rx_if;
  import printer_pkg::*;

  logic            i_tr;
  logic [PD_W-1:0] i_pd;
  logic            o_rdy;
  logic [PD_W-1:0] o_data;
  logic            o_valid;
  logic            i_ready;
  logic [15:0]     o_char_cnt;
  logic            o_err;

  // printer side
  modport slave (
    input  i_tr, i_pd, i_ready,
    output o_rdy, o_data, o_valid, o_char_cnt, o_err
  );

  // POC / consumer side
  modport master (
    output i_tr, i_pd, i_ready,
    input  o_rdy, o_data, o_valid, o_char_cnt, o_err
  );

endinterface

// File: rtl/printer_rx_byte_fifo.sv
// First-word fall-through FIFO; dout keeps the last popped word while empty.
module byte_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [W-1:0]  hold_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? hold_q : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      hold_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        hold_q <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/printer_rx.sv
// Printer endpoint: accepts a character per strobe, holds o_rdy low for the print time,
// queues characters for a downstream consumer.
//   state | meaning
//   READY | o_rdy=1, waiting for a strobe
//   BUSY  | printing, busy counter runs down to 0
//   STALL | print done but queue full, waiting for a consumer pop
module printer_rx
  import printer_pkg::*;
#(
  parameter int PRINT_CYCLES = PRINT_CYCLES_DEF,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  printer_rx_if.slave bus
);

  localparam logic [1:0] READY = ST_READY;
  localparam logic [1:0] BUSY  = ST_BUSY;
  localparam logic [1:0] STALL = ST_STALL;
  localparam int CNT_W = (PRINT_CYCLES > 1) ? $clog2(PRINT_CYCLES) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]       state;
  logic [CNT_W-1:0] busy_cnt;
  logic [15:0]      char_cnt;
  logic             err;

  logic             accept;
  logic             pop;
  logic             go_stall;
  logic             fifo_empty;
  logic             fifo_full;
  logic [PD_W-1:0]  fifo_dout;
  logic [CW-1:0]    fifo_count;

  assign accept   = (state == READY) && bus.i_tr;
  assign pop      = !fifo_empty && bus.i_ready;
  // BUSY never pushes, so the post-edge count is full only if nothing pops now
  assign go_stall = (fifo_count == CW'(FIFO_DEPTH)) && !pop;

  byte_fifo #(
    .W     (PD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (accept && !fifo_full),
    .pop   (pop),
    .din   (bus.i_pd),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= READY;
      busy_cnt <= '0;
      char_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (bus.i_tr && state != READY) err <= 1'b1;
      case (state)
        READY: begin
          if (accept) begin
            state    <= BUSY;
            busy_cnt <= CNT_W'(PRINT_CYCLES - 1);
            char_cnt <= char_cnt + 16'd1;
          end
        end
        BUSY: begin
          if (busy_cnt == '0) state <= go_stall ? STALL : READY;
          else                busy_cnt <= busy_cnt - CNT_W'(1);
        end
        STALL: begin
          if (pop) state <= READY;
        end
        default: state <= READY;
      endcase
    end
  end

  assign bus.o_rdy      = (state == READY);
  assign bus.o_valid    = !fifo_empty;
  assign bus.o_data     = fifo_dout;
  assign bus.o_char_cnt = char_cnt;
  assign bus.o_err      = err;

endmodule
